// File: rtl/control_unit.sv
// Main instruction decoder: InstHeader -> datapath control for ALU, PAU, memories, IO, branch.
// Latency: one cycle; every output is a flop loaded on each rising clk edge.
// No backpressure: a new header is decoded every cycle; rst forces all outputs to a NOP (all zero).
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] InstHeader,
  output logic       RnSrc,
  output logic       ImmSrc,
  output logic       RsSrc,
  output logic       ResultSrc,
  output logic       IOFlag,
  output logic       PAUOp,
  output logic       ImmExt,
  output logic       FlagWrite,
  output logic       ALUSrc,
  output logic       BranchInst,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemPWrite,
  output logic [3:0] ALUControl,
  output logic [2:0] CondFlag,
  output logic [1:0] MemToReg
);

  logic [2:0] cond;
  logic [1:0] cls;
  logic [3:0] op;
  logic       imm;

  assign cond = InstHeader[9:7];
  assign cls  = InstHeader[6:5];
  assign op   = InstHeader[4:1];
  assign imm  = InstHeader[0];

  logic       rn_src_d,      rn_src_q;
  logic       imm_src_d,     imm_src_q;
  logic       rs_src_d,      rs_src_q;
  logic       result_src_d,  result_src_q;
  logic       io_flag_d,     io_flag_q;
  logic       pau_op_d,      pau_op_q;
  logic       imm_ext_d,     imm_ext_q;
  logic       flag_write_d,  flag_write_q;
  logic       alu_src_d,     alu_src_q;
  logic       branch_inst_d, branch_inst_q;
  logic       mem_write_d,   mem_write_q;
  logic       reg_write_d,   reg_write_q;
  logic       mem_p_write_d, mem_p_write_q;
  logic [3:0] alu_control_d, alu_control_q;
  logic [2:0] cond_flag_d,   cond_flag_q;
  logic [1:0] mem_to_reg_d,  mem_to_reg_q;

  // Combinational decode of the header into next-cycle control values.
  always_comb begin
    rn_src_d      = 1'b0;
    imm_src_d     = 1'b0;
    rs_src_d      = 1'b0;
    result_src_d  = 1'b0;
    io_flag_d     = 1'b0;
    pau_op_d      = 1'b0;
    imm_ext_d     = 1'b0;
    flag_write_d  = 1'b0;
    alu_src_d     = 1'b0;
    branch_inst_d = 1'b0;
    mem_write_d   = 1'b0;
    reg_write_d   = 1'b0;
    mem_p_write_d = 1'b0;
    alu_control_d = 4'b0000;
    cond_flag_d   = cond;
    mem_to_reg_d  = 2'b00;

    case (cls)
      // Data processing; reserved opcodes 1100-1111 fall to the default and stay a NOP.
      2'b00: begin
        case (op)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111: begin
            alu_control_d = op;
            alu_src_d     = imm;
            reg_write_d   = 1'b1;
          end
          4'b0101, 4'b0110, 4'b1011: begin
            // Register-form shifts take the shift amount from the Rs field.
            alu_control_d = op;
            alu_src_d     = imm;
            reg_write_d   = 1'b1;
            rs_src_d      = ~imm;
          end
          4'b1001: begin
            // MOV is ADD with a zero first operand.
            alu_control_d = op;
            alu_src_d     = imm;
            reg_write_d   = 1'b1;
            rn_src_d      = 1'b1;
          end
          4'b1000, 4'b1010: begin
            // TST/CMP only update flags.
            alu_control_d = op;
            alu_src_d     = imm;
            flag_write_d  = 1'b1;
          end
          default: ;
        endcase
      end
      // Memory: address = Rn + imm12; op[3] = load, op[2] = pixel memory.
      2'b01: begin
        alu_src_d     = 1'b1;
        alu_control_d = 4'b0001;
        if (op[3]) begin
          reg_write_d  = 1'b1;
          mem_to_reg_d = op[2] ? 2'b10 : 2'b01;
        end else begin
          rs_src_d      = 1'b1;
          mem_write_d   = ~op[2];
          mem_p_write_d = op[2];
        end
      end
      // Branch: target = PC + sign-extended 24-bit offset; op[3] = link.
      2'b10: begin
        branch_inst_d = 1'b1;
        rn_src_d      = 1'b1;
        imm_src_d     = 1'b1;
        imm_ext_d     = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = 4'b0001;
        reg_write_d   = op[3];
      end
      // Pixel arithmetic (op[3] = 0) or IO port access (op[3] = 1).
      default: begin
        if (!op[3]) begin
          pau_op_d      = 1'b1;
          result_src_d  = 1'b1;
          reg_write_d   = 1'b1;
          alu_src_d     = imm;
          alu_control_d = {1'b0, op[2:0]};
        end else begin
          io_flag_d = 1'b1;
          if (op[2]) begin
            rs_src_d = 1'b1;
          end else begin
            reg_write_d  = 1'b1;
            mem_to_reg_d = 2'b11;
          end
        end
      end
    endcase
  end

  // Register the decoded controls; reset clears everything to a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rn_src_q      <= 1'b0;
      imm_src_q     <= 1'b0;
      rs_src_q      <= 1'b0;
      result_src_q  <= 1'b0;
      io_flag_q     <= 1'b0;
      pau_op_q      <= 1'b0;
      imm_ext_q     <= 1'b0;
      flag_write_q  <= 1'b0;
      alu_src_q     <= 1'b0;
      branch_inst_q <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_p_write_q <= 1'b0;
      alu_control_q <= 4'b0000;
      cond_flag_q   <= 3'b000;
      mem_to_reg_q  <= 2'b00;
    end else begin
      rn_src_q      <= rn_src_d;
      imm_src_q     <= imm_src_d;
      rs_src_q      <= rs_src_d;
      result_src_q  <= result_src_d;
      io_flag_q     <= io_flag_d;
      pau_op_q      <= pau_op_d;
      imm_ext_q     <= imm_ext_d;
      flag_write_q  <= flag_write_d;
      alu_src_q     <= alu_src_d;
      branch_inst_q <= branch_inst_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      mem_p_write_q <= mem_p_write_d;
      alu_control_q <= alu_control_d;
      cond_flag_q   <= cond_flag_d;
      mem_to_reg_q  <= mem_to_reg_d;
    end
  end

  assign RnSrc      = rn_src_q;
  assign ImmSrc     = imm_src_q;
  assign RsSrc      = rs_src_q;
  assign ResultSrc  = result_src_q;
  assign IOFlag     = io_flag_q;
  assign PAUOp      = pau_op_q;
  assign ImmExt     = imm_ext_q;
  assign FlagWrite  = flag_write_q;
  assign ALUSrc     = alu_src_q;
  assign BranchInst = branch_inst_q;
  assign MemWrite   = mem_write_q;
  assign RegWrite   = reg_write_q;
  assign MemPWrite  = mem_p_write_q;
  assign ALUControl = alu_control_q;
  assign CondFlag   = cond_flag_q;
  assign MemToReg   = mem_to_reg_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: hand-computed expectations per header.
// Inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [9:0] InstHeader;
  logic       RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt, FlagWrite;
  logic       ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite;
  logic [3:0] ALUControl;
  logic [2:0] CondFlag;
  logic [1:0] MemToReg;

  int n_checks = 0;
  int n_fails  = 0;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .InstHeader (InstHeader),
    .RnSrc      (RnSrc),
    .ImmSrc     (ImmSrc),
    .RsSrc      (RsSrc),
    .ResultSrc  (ResultSrc),
    .IOFlag     (IOFlag),
    .PAUOp      (PAUOp),
    .ImmExt     (ImmExt),
    .FlagWrite  (FlagWrite),
    .ALUSrc     (ALUSrc),
    .BranchInst (BranchInst),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemPWrite  (MemPWrite),
    .ALUControl (ALUControl),
    .CondFlag   (CondFlag),
    .MemToReg   (MemToReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all outputs:
  // {RnSrc,ImmSrc,RsSrc,ResultSrc,IOFlag,PAUOp,ImmExt,FlagWrite,ALUSrc,BranchInst,
  //  MemWrite,RegWrite,MemPWrite,ALUControl[3:0],CondFlag[2:0],MemToReg[1:0]}
  logic [21:0] out_vec;
  assign out_vec = {RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt, FlagWrite,
                    ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite,
                    ALUControl, CondFlag, MemToReg};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a header on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic [9:0] hdr);
    @(negedge clk);
    InstHeader = hdr;
    @(posedge clk);
    #1;
  endtask

  // DP sweep table
  logic [9:0] dp_hdr [8];
  logic [3:0] dp_alu [8];
  logic       dp_rn  [8];
  logic       dp_rs  [8];

  initial begin
    dp_hdr[0] = 10'b0000000010; dp_alu[0] = 4'b0001; dp_rn[0] = 1'b0; dp_rs[0] = 1'b0;
    dp_hdr[1] = 10'b0000010010; dp_alu[1] = 4'b1001; dp_rn[1] = 1'b1; dp_rs[1] = 1'b0;
    dp_hdr[2] = 10'b0000000111; dp_alu[2] = 4'b0011; dp_rn[2] = 1'b0; dp_rs[2] = 1'b0;
    dp_hdr[3] = 10'b0000001010; dp_alu[3] = 4'b0101; dp_rn[3] = 1'b0; dp_rs[3] = 1'b1;
    dp_hdr[4] = 10'b0000001011; dp_alu[4] = 4'b0101; dp_rn[4] = 1'b0; dp_rs[4] = 1'b0;
    dp_hdr[5] = 10'b0000000011; dp_alu[5] = 4'b0001; dp_rn[5] = 1'b0; dp_rs[5] = 1'b0;
    dp_hdr[6] = 10'b0000010011; dp_alu[6] = 4'b1001; dp_rn[6] = 1'b1; dp_rs[6] = 1'b0;
    dp_hdr[7] = 10'b0000010111; dp_alu[7] = 4'b1011; dp_rn[7] = 1'b0; dp_rs[7] = 1'b0;

    rst = 1'b1;
    InstHeader = 10'b0000000010;
    #12;
    check_eq("reset_initial_all_zero", {10'b0, out_vec}, 32'h0);

    // Reset held across an edge keeps outputs at zero.
    @(posedge clk);
    #1;
    check_eq("reset_held_over_edge", {10'b0, out_vec}, 32'h0);

    // Release and run a decode so outputs are non-zero.
    @(negedge clk);
    rst = 1'b0;
    step(10'b1110000010);
    check_eq("pre_reset_regwrite", {31'b0, RegWrite}, 32'd1);
    check_eq("pre_reset_cond", {29'b0, CondFlag}, 32'd7);

    // Asynchronous reset mid-cycle: outputs clear without an edge.
    InstHeader = 10'b0000000010;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset_all_zero", {10'b0, out_vec}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_reset_regwrite", {31'b0, RegWrite}, 32'd1);
    check_eq("post_reset_alu", {28'b0, ALUControl}, 32'd1);
    check_eq("post_reset_alusrc", {31'b0, ALUSrc}, 32'd0);
    check_eq("post_reset_cond", {29'b0, CondFlag}, 32'd0);

    // Data-processing sweep.
    for (int i = 0; i < 8; i++) begin
      step(dp_hdr[i]);
      check_eq($sformatf("dp%0d_alu", i), {28'b0, ALUControl}, {28'b0, dp_alu[i]});
      check_eq($sformatf("dp%0d_alusrc", i), {31'b0, ALUSrc}, {31'b0, dp_hdr[i][0]});
      check_eq($sformatf("dp%0d_rnsrc", i), {31'b0, RnSrc}, {31'b0, dp_rn[i]});
      check_eq($sformatf("dp%0d_rssrc", i), {31'b0, RsSrc}, {31'b0, dp_rs[i]});
      check_eq($sformatf("dp%0d_regwrite", i), {31'b0, RegWrite}, 32'd1);
      check_eq($sformatf("dp%0d_flagwrite", i), {31'b0, FlagWrite}, 32'd0);
    end

    // Header change between edges has no effect until the next edge.
    @(negedge clk);
    InstHeader = 10'b0001110000;
    #2;
    check_eq("hold_between_edges_alu", {28'b0, ALUControl}, 32'd11);
    check_eq("hold_between_edges_io", {31'b0, IOFlag}, 32'd0);

    // Memory: data store.
    step(10'b0000100000);
    check_eq("st_memwrite", {31'b0, MemWrite}, 32'd1);
    check_eq("st_mempwrite", {31'b0, MemPWrite}, 32'd0);
    check_eq("st_rssrc", {31'b0, RsSrc}, 32'd1);
    check_eq("st_regwrite", {31'b0, RegWrite}, 32'd0);
    check_eq("st_alusrc", {31'b0, ALUSrc}, 32'd1);
    check_eq("st_alu", {28'b0, ALUControl}, 32'd1);

    // Memory: pixel load.
    step(10'b0000111000);
    check_eq("pld_regwrite", {31'b0, RegWrite}, 32'd1);
    check_eq("pld_memtoreg", {30'b0, MemToReg}, 32'd2);
    check_eq("pld_memwrite", {31'b0, MemWrite}, 32'd0);
    check_eq("pld_mempwrite", {31'b0, MemPWrite}, 32'd0);

    // Memory: data load and pixel store.
    step(10'b0000110000);
    check_eq("ld_memtoreg", {30'b0, MemToReg}, 32'd1);
    step(10'b0000101000);
    check_eq("pst_mempwrite", {31'b0, MemPWrite}, 32'd1);
    check_eq("pst_memwrite", {31'b0, MemWrite}, 32'd0);
    check_eq("pst_rssrc", {31'b0, RsSrc}, 32'd1);

    // Branch without and with link.
    step(10'b0001000000);
    check_eq("b_branch", {31'b0, BranchInst}, 32'd1);
    check_eq("b_immsrc", {31'b0, ImmSrc}, 32'd1);
    check_eq("b_immext", {31'b0, ImmExt}, 32'd1);
    check_eq("b_rnsrc", {31'b0, RnSrc}, 32'd1);
    check_eq("b_regwrite", {31'b0, RegWrite}, 32'd0);
    step(10'b0001010000);
    check_eq("bl_regwrite", {31'b0, RegWrite}, 32'd1);
    check_eq("bl_memtoreg", {30'b0, MemToReg}, 32'd0);

    // CMP with cond 111.
    step(10'b1110010100);
    check_eq("cmp_flagwrite", {31'b0, FlagWrite}, 32'd1);
    check_eq("cmp_regwrite", {31'b0, RegWrite}, 32'd0);
    check_eq("cmp_cond", {29'b0, CondFlag}, 32'd7);
    check_eq("cmp_alu", {28'b0, ALUControl}, 32'd10);

    // Reserved DP opcode: only CondFlag survives (cond 101).
    step(10'b1010011001);
    check_eq("reserved_all", {10'b0, out_vec}, {10'b0, 17'b0, 3'b101, 2'b00});

    // Pixel arithmetic.
    step(10'b0001100010);
    check_eq("pau_op", {31'b0, PAUOp}, 32'd1);
    check_eq("pau_resultsrc", {31'b0, ResultSrc}, 32'd1);
    check_eq("pau_regwrite", {31'b0, RegWrite}, 32'd1);
    check_eq("pau_alu", {28'b0, ALUControl}, 32'd1);

    // IO read and IO write.
    step(10'b0001110000);
    check_eq("ior_ioflag", {31'b0, IOFlag}, 32'd1);
    check_eq("ior_memtoreg", {30'b0, MemToReg}, 32'd3);
    check_eq("ior_regwrite", {31'b0, RegWrite}, 32'd1);
    step(10'b0001111000);
    check_eq("iow_ioflag", {31'b0, IOFlag}, 32'd1);
    check_eq("iow_rssrc", {31'b0, RsSrc}, 32'd1);
    check_eq("iow_regwrite", {31'b0, RegWrite}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder of the hybrid ARM/MIPS core.
- Decodes the 10-bit instruction header (condition, class, opcode, immediate bit) into datapath control signals for ALU, pixel arithmetic unit (PAU), data memory, pixel memory, IO and branch logic.
- Outputs are registered: one decode cycle, then the signals feed the execute/memory/writeback muxes.

Parameters:
None.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- InstHeader  input  10  instruction header. Fields:
  - [9:7] cond
  - [6:5] class
  - [4:1] op
  - [0] I (immediate)
- RnSrc  output  1  1 = first read port uses zero register (MOV) or PC (branch) instead of Rn.
- ImmSrc  output  1  0 = 12-bit immediate field, 1 = 24-bit branch offset.
- RsSrc  output  1  1 = second read port takes Rs/Rd field (register shift amount, store data).
- ResultSrc  output  1  execute result: 0 = ALU, 1 = PAU.
- IOFlag  output  1  IO-port instruction.
- PAUOp  output  1  PAU operation active.
- ImmExt  output  1  1 = sign-extend immediate, 0 = zero-extend.
- FlagWrite  output  1  update NZCV flags.
- ALUSrc  output  1  ALU B operand: 0 = register, 1 = immediate.
- BranchInst  output  1  branch instruction.
- MemWrite  output  1  data-memory write enable.
- RegWrite  output  1  register-file write enable.
- MemPWrite  output  1  pixel-memory write enable.
- ALUControl  output  4  ALU operation code.
- CondFlag  output  3  condition code; 111 = always.
- MemToReg  output  2  writeback select: 00 execute result, 01 data memory, 10 pixel memory, 11 IO port.

Behaviour:
- All outputs registered on rising clk from the combinational decode of InstHeader; latency 1 cycle.
- rst asserted (async): every output 0 immediately, held 0 while rst high. This equals a NOP. First decode is captured on the first rising edge after rst falls.
- Defaults: every signal 0 unless set below.
- CondFlag = InstHeader[9:7] for every class.
- Class 00, data processing. ALUControl = op, ALUSrc = I, ImmSrc = 0, ImmExt = 0, MemToReg = 00. Opcodes:
  - 0000 AND, 0001 ADD, 0010 SUB, 0011 ORR, 0100 EOR.
  - 0101 LSL, 0110 LSR, 1011 ASR: shifts; RsSrc = ~I.
  - 0111 MUL.
  - 1001 MOV: RnSrc = 1.
  - 1000 TST, 1010 CMP: RegWrite = 0, FlagWrite = 1.
  - All other listed ops: RegWrite = 1, FlagWrite = 0.
  - 1100-1111 reserved: all zero except CondFlag.
- Class 01, memory. ALUSrc = 1, ALUControl = 0001, ImmSrc = 0, ImmExt = 0. Field op[3] (InstHeader[4]) = L, op[2] (InstHeader[3]) = P (pixel).
  - L=1: RegWrite = 1; MemToReg = 01 if P=0, 10 if P=1.
  - L=0: RsSrc = 1; MemWrite = ~P, MemPWrite = P.
  - InstHeader[2:0] ignored.
- Class 10, branch. BranchInst = 1, RnSrc = 1, ImmSrc = 1, ImmExt = 1, ALUSrc = 1, ALUControl = 0001. InstHeader[4] = link: RegWrite = 1, MemToReg = 00.
- Class 11, pixel/IO.
  - InstHeader[4] = 0: PAUOp = 1, ResultSrc = 1, RegWrite = 1, ALUSrc = I, MemToReg = 00, ALUControl = {1'b0, InstHeader[3:1]} (PAU sub-op).
  - InstHeader[4] = 1: IOFlag = 1. InstHeader[3] = 1 is IO write (RsSrc = 1, RegWrite = 0). InstHeader[3] = 0 is IO read (RegWrite = 1, MemToReg = 11).
- Never assert MemWrite and MemPWrite together.
- Header changes between edges have no output effect until the next edge.

Test Plan:
- Reset: rst=1 mid-operation with InstHeader=0000000010 -> all outputs 0 without waiting for a clock edge. Release, then one edge -> RegWrite=1, ALUControl=0001, ALUSrc=0, CondFlag=000.
- DP sweep: 0000000010 / 0000010010 / 0000000111 / 0000001010 / 0000001011 / 0000000011 / 0000010011 / 0000010111, each checked one cycle later:
  - ALUControl 0001 / 1001 / 0011 / 0101 / 0101 / 0001 / 1001 / 1011.
  - ALUSrc = bit0.
  - RnSrc=1 for the MOV cases.
  - RsSrc=1 only for 0000001010.
  - RegWrite=1 for all.
- Memory: 0000100000 -> MemWrite=1, RsSrc=1, RegWrite=0, ALUSrc=1. 0000111000 -> RegWrite=1, MemToReg=10, MemWrite=MemPWrite=0.
- Branch: 0001000000 -> BranchInst=1, ImmSrc=1, ImmExt=1, RegWrite=0. 0001010000 -> RegWrite=1.
- Flags/cond: 1110010100 (CMP, cond 111) -> FlagWrite=1, RegWrite=0, CondFlag=111.
- Pixel/IO: 0001100010 -> PAUOp=1, ResultSrc=1. 0001110000 -> IOFlag=1, MemToReg=11, RegWrite=1.
